alu16_seq: RTL and testbench

- Sequencer for the SM83 CPU's 16-bit arithmetic: ADD HL,rr; ADD SP,e8; INC rr; DEC rr.
- Runs each operation as two passes, low byte then high byte, through the existing 8-bit ALU.
- Sits between the decode/register-file stage and the 8-bit ALU: drives the ALU operand/op/flag inputs, captures its outputs, returns a registered 16-bit result plus flags.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu8.sv | 61 ++++++
 rtl/alu16_seq.sv | 138 +++++++++++++
 tb/tb_alu16_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the SM83 8-bit ALU and the 16-bit arithmetic sequencer:
// ALU op selects, ZNHC flag bit positions, 16-bit op codes and sequencer states.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_ADC = 5'b00001,
        ALU_SUB = 5'b00010,
        ALU_SBC = 5'b00011,
        ALU_AND = 5'b00100,
        ALU_XOR = 5'b00101,
        ALU_OR  = 5'b00110,
        ALU_CP  = 5'b00111
    } alu_op_e;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_H = 1;
    localparam int F_C = 0;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'd0,
        OP_ADDSP = 2'd1,
        OP_INC16 = 2'd2,
        OP_DEC16 = 2'd3
    } op16_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu8.sv
// Combinational SM83 8-bit ALU: computes b op a, returning the result and ZNHC.
// C is carry out for additions and borrow for subtractions.
module alu8
    import alu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [4:0] i_op,
    input  logic [3:0] i_flags,
    output logic [7:0] o_result,
    output logic [3:0] o_flags
);

    logic       w_cin;
    logic [8:0] w_full;
    logic [4:0] w_half;
    logic [7:0] w_res;
    logic       w_unused;

    // Only the incoming carry matters to this ALU.
    assign w_unused = &{1'b0, i_flags[F_Z], i_flags[F_N], i_flags[F_H]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cin   = 1'b0;
        w_full  = '0;
        w_half  = '0;
        w_res   = '0;
        o_flags = '0;
        case (alu_op_e'(i_op))
            ALU_ADD, ALU_ADC: begin
                w_cin  = (i_op == ALU_ADC) ? i_flags[F_C] : 1'b0;
                w_full = {1'b0, i_b} + {1'b0, i_a} + {8'b0, w_cin};
                w_half = {1'b0, i_b[3:0]} + {1'b0, i_a[3:0]} + {4'b0, w_cin};
                w_res  = w_full[7:0];
                o_flags[F_H] = w_half[4];
                o_flags[F_C] = w_full[8];
            end
            ALU_SUB, ALU_SBC, ALU_CP: begin
                w_cin  = (i_op == ALU_SBC) ? i_flags[F_C] : 1'b0;
                w_full = {1'b0, i_b} - {1'b0, i_a} - {8'b0, w_cin};
                w_half = {1'b0, i_b[3:0]} - {1'b0, i_a[3:0]} - {4'b0, w_cin};
                w_res  = w_full[7:0];
                o_flags[F_N] = 1'b1;
                o_flags[F_H] = w_half[4];
                o_flags[F_C] = w_full[8];
            end
            ALU_AND: begin
                w_res = i_b & i_a;
                o_flags[F_H] = 1'b1;
            end
            ALU_XOR: w_res = i_b ^ i_a;
            ALU_OR:  w_res = i_b | i_a;
            default: w_res = '0;
        endcase
        o_flags[F_Z] = (w_res == 8'h00);
        // Compare leaves the accumulator untouched.
        o_result = (i_op == ALU_CP) ? i_b : w_res;
    end

endmodule

// File: rtl/alu16_seq.sv
// SM83 16-bit arithmetic sequencer: runs ADD HL,rr / ADD SP,e8 / INC rr / DEC rr
// as a low-byte pass then a high-byte pass through the external 8-bit ALU.
module alu16_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    state_e      r_state;
    state_e      w_next_state;
    op16_e       r_op;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [3:0]  r_flags;
    logic [7:0]  r_lo_byte;
    logic        r_lo_h;
    logic        r_lo_c;
    logic [15:0] r_result;
    logic [3:0]  r_flags_out;
    logic [3:0]  w_hi_flags;
    logic        w_accept;
    logic        w_unused;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_unused = &{1'b0, alu_flags_out[F_Z], alu_flags_out[F_N]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_LO;
            ST_LO:   w_next_state = ST_HI;
            ST_HI:   w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = ALU_ADD;
        alu_flags_in = '0;
        case (r_state)
            ST_LO: begin
                alu_b = r_opa[7:0];
                case (r_op)
                    OP_ADD16, OP_ADDSP: alu_a = r_opb[7:0];
                    OP_INC16:           alu_a = 8'h01;
                    default: begin
                        alu_a  = 8'h01;
                        alu_op = ALU_SUB;
                    end
                endcase
            end
            ST_HI: begin
                alu_b              = r_opa[15:8];
                alu_flags_in[F_C]  = r_lo_c;
                alu_op             = ALU_ADC;
                case (r_op)
                    OP_ADD16: alu_a = r_opb[15:8];
                    OP_ADDSP: alu_a = {8{r_opb[7]}};
                    OP_INC16: alu_a = 8'h00;
                    default: begin
                        alu_a  = 8'h00;
                        alu_op = ALU_SBC;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // ADD SP,e8 reports the unsigned low-byte carries; INC/DEC leave flags alone.
    always_comb begin
        w_hi_flags = r_flags;
        case (r_op)
            OP_ADD16: w_hi_flags = {r_flags[F_Z], 1'b0, alu_flags_out[F_H], alu_flags_out[F_C]};
            OP_ADDSP: w_hi_flags = {2'b00, r_lo_h, r_lo_c};
            default:  w_hi_flags = r_flags;
        endcase
    end

    // NOTE: operand and low-pass holding registers are left unreset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= op16_e'(op);
            r_opa   <= opa;
            r_opb   <= opb;
            r_flags <= flags_in;
        end
        if (r_state == ST_LO) begin
            r_lo_byte <= alu_result;
            r_lo_h    <= alu_flags_out[F_H];
            r_lo_c    <= alu_flags_out[F_C];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_flags_out <= '0;
        end else if (r_state == ST_HI) begin
            r_result    <= {alu_result, r_lo_byte};
            r_flags_out <= w_hi_flags;
        end
    end

    assign result    = r_result;
    assign flags_out = r_flags_out;

endmodule

// File: tb/tb_alu16_seq.sv
// Self-checking bench for alu16_seq wired to the real 8-bit ALU; results are
// compared against a plain-arithmetic model of the SM83 16-bit operations.
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_flags_in(alu_flags_in), .alu_result(alu_result),
        .alu_flags_out(alu_flags_out)
    );

    alu8 u_alu (
        .i_a(alu_a), .i_b(alu_b), .i_op(alu_op), .i_flags(alu_flags_in),
        .o_result(alu_result), .o_flags(alu_flags_out)
    );

    // Reference: whole 16-bit arithmetic with integer sums, flags from carry thresholds.
    function automatic void model(input logic [1:0] m_op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [3:0] f,
                                  output logic [15:0] r, output logic [3:0] fo);
        int s;
        int e;
        case (m_op)
            2'd0: begin
                s  = int'(a) + int'(b);
                r  = 16'(s & 32'hFFFF);
                fo = {f[3], 1'b0, (int'(a & 16'h0FFF) + int'(b & 16'h0FFF)) > 32'h0FFF, s > 32'hFFFF};
            end
            2'd1: begin
                e  = int'(b[7:0]);
                if (e >= 128) e = e - 256;
                s  = int'(a) + e;
                r  = 16'(s & 32'hFFFF);
                fo = {2'b00, (int'(a[3:0]) + int'(b[3:0])) > 15, (int'(a[7:0]) + int'(b[7:0])) > 255};
            end
            2'd2: begin
                r  = a + 16'd1;
                fo = f;
            end
            default: begin
                r  = a - 16'd1;
                fo = f;
            end
        endcase
    endfunction

    task automatic do_op(input string name, input logic [1:0] op_v, input logic [15:0] a_v,
                         input logic [15:0] b_v, input logic [3:0] f_v,
                         input logic [15:0] exp_r, input logic [3:0] exp_f);
        @(negedge clk);
        start = 1'b1; op = op_v; opa = a_v; opb = b_v; flags_in = f_v;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0; op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom);
            flags_in = 4'($urandom);
            checks++;
            if (done !== (k == 3)) begin
                errors++;
                $display("FAIL %s done cyc%0d got %b exp %b", name, k, done, (k == 3));
            end
            checks++;
            if (busy !== (k <= 3)) begin
                errors++;
                $display("FAIL %s busy cyc%0d got %b exp %b", name, k, busy, (k <= 3));
            end
            if (k >= 3) begin
                checks++;
                if (result !== exp_r) begin
                    errors++;
                    $display("FAIL %s result cyc%0d got %h exp %h", name, k, result, exp_r);
                end
                checks++;
                if (flags_out !== exp_f) begin
                    errors++;
                    $display("FAIL %s flags cyc%0d got %b exp %b", name, k, flags_out, exp_f);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; flags_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset busy_done got %b exp 00", {busy, done});
        end
        checks++;
        if ({result, flags_out} !== 20'h0) begin
            errors++;
            $display("FAIL reset result_flags got %h exp 00000", {result, flags_out});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, alu_flags_in} !== 25'h0) begin
            errors++;
            $display("FAIL reset alu_drive got %h exp 0", {alu_a, alu_b, alu_op, alu_flags_in});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_op("add16_h",     2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
        do_op("add16_wrap",  2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
        do_op("addsp_pos",   2'd1, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011);
        do_op("addsp_neg",   2'd1, 16'h1000, 16'h00FF, 4'b1111, 16'h0FFF, 4'b0000);
        do_op("dec16_wrap",  2'd3, 16'h0000, 16'h1234, 4'b1010, 16'hFFFF, 4'b1010);
        do_op("inc16_wrap",  2'd2, 16'hFFFF, 16'h5555, 4'b0101, 16'h0000, 4'b0101);
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [15:0] r_a;
        logic [15:0] r_b;
        logic [3:0]  r_f;
        logic [15:0] e_r;
        logic [3:0]  e_f;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            r_f  = 4'($urandom);
            model(r_op, r_a, r_b, r_f, e_r, e_f);
            do_op("random", r_op, r_a, r_b, r_f, e_r, e_f);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [15:0] e_r;
        logic [3:0]  e_f;
        model(2'd0, 16'h1234, 16'h0F0F, 4'b0000, e_r, e_f);
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 16'h1234; opb = 16'h0F0F; flags_in = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            checks++;
            if (done !== (k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b done cyc%0d got %b exp %b", k, done, (k == 3 || k == 7));
            end
            if (k == 7) begin
                checks++;
                if (result !== e_r) begin
                    errors++;
                    $display("FAIL b2b result got %h exp %h", result, e_r);
                end
            end
            if (k == 7) start = 1'b0;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b pulse_count got %0d exp 2", pulses);
        end
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        start = 1'b1; op = 2'd2; opa = 16'h00FF; opb = 16'h0000; flags_in = 4'b0110;
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 16'h8000; opb = 16'hFFFF; flags_in = 4'b1001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 16'h0100 || flags_out !== 4'b0110) begin
            errors++;
            $display("FAIL ignore first_op got done=%b %h/%b exp 1 0100/0110", done, result, flags_out);
        end
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore extra_op cyc%0d got busy=%b done=%b exp 0 0", k, busy, done);
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 16'h4000; opb = 16'h4000; flags_in = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort busy_before got %b exp 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00 || result !== 16'h0000 || flags_out !== 4'b0000) begin
            errors++;
            $display("FAIL abort cleared got busy=%b done=%b %h/%b exp 0 0 0000/0000",
                     busy, done, result, flags_out);
        end
        rst = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== 16'h0000) begin
                errors++;
                $display("FAIL abort no_done cyc%0d got done=%b result=%h exp 0 0000", k, done, result);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
